// File: rtl/prog_sequencer.sv
// Program sequencer: launches one of three core programs per host request edge,
// supervises the run with a cycle counter and timeout, and reports completion.
module prog_sequencer #(
  parameter int unsigned PW  = 10,
  parameter int unsigned PC0 = 0,
  parameter int unsigned PC1 = 128,
  parameter int unsigned PC2 = 256,
  parameter logic [15:0] TMO = 16'd60000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic          core_start,
  output logic [PW-1:0] core_pc,
  input  logic          core_done,
  output logic [1:0]    prog_id,
  output logic          busy,
  output logic          timeout,
  output logic [15:0]   last_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic        req_q;
  logic        ack_q, ack_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  prog_id_q, prog_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] last_q, last_d;
  logic        launch;
  logic [1:0]  prog_id_next;
  logic [PW-1:0] pc_sel;

  // Only a fresh edge seen while idle starts a program; edges while busy are dropped.
  assign launch = (state_q == StIdle) && req && !req_q;

  assign prog_id_next = (prog_id_q == 2'd2) ? 2'd0 : prog_id_q + 2'd1;

  always_comb begin
    pc_sel = '0;
    unique case (prog_id_q)
      2'd0:    pc_sel = PW'(PC0);
      2'd1:    pc_sel = PW'(PC1);
      default: pc_sel = PW'(PC2);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    prog_id_d = prog_id_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d   = StLaunch;
          ack_d     = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      StLaunch: begin
        state_d = StRun;
        cnt_d   = 16'd1;
      end
      StRun: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (core_done) begin
          state_d   = StIdle;
          ack_d     = 1'b1;
          last_d    = cnt_q;
          prog_id_d = prog_id_next;
        end else if (cnt_q == TMO) begin
          state_d   = StIdle;
          ack_d     = 1'b1;
          timeout_d = 1'b1;
          last_d    = TMO;
          prog_id_d = prog_id_next;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      prog_id_q <= 2'd0;
      cnt_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      prog_id_q <= prog_id_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign core_start  = (state_q == StLaunch);
  assign core_pc     = core_start ? pc_sel : '0;
  assign busy        = (state_q != StIdle);
  assign ack         = ack_q;
  assign timeout     = timeout_q;
  assign prog_id     = prog_id_q;
  assign last_cycles = last_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: expected launches and results are queued
// as stimulus is driven and checked when core_start / ack appear.
module tb_prog_sequencer;

  localparam int unsigned TmoTb = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        core_done = 1'b0;
  logic        ack, core_start, busy, timeout;
  logic [9:0]  core_pc;
  logic [1:0]  prog_id;
  logic [15:0] last_cycles;

  prog_sequencer #(
    .PW (10),
    .PC0(0),
    .PC1(128),
    .PC2(256),
    .TMO(16'd20)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .core_start (core_start),
    .core_pc    (core_pc),
    .core_done  (core_done),
    .prog_id    (prog_id),
    .busy       (busy),
    .timeout    (timeout),
    .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    bit tmo;
    int id;
  } res_t;

  int   exp_pc_q[$];
  res_t exp_res_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  int   exp_starts = 0;
  int   m_id = 0;
  logic ack_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pc_of(input int id);
    case (id)
      0:       return 0;
      1:       return 128;
      default: return 256;
    endcase
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (core_start) begin
      n_starts++;
      if (exp_pc_q.size() == 0) begin
        check_eq("unexpected_start", 1, 0);
      end else begin
        check_eq("core_pc", 32'(core_pc), 32'(exp_pc_q.pop_front()));
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_ack", 32'(ack), 0);
        check_eq("start_timeout", 32'(timeout), 0);
      end
    end else begin
      check_eq("pc_idle_zero", 32'(core_pc), 0);
    end
    if (ack && !ack_prev) begin
      if (exp_res_q.size() == 0) begin
        check_eq("unexpected_ack", 1, 0);
      end else begin
        res_t r;
        r = exp_res_q.pop_front();
        check_eq("last_cycles", 32'(last_cycles), 32'(r.cycles));
        check_eq("timeout", 32'(timeout), 32'(r.tmo));
        check_eq("prog_id", 32'(prog_id), 32'(r.id));
        check_eq("ack_busy", 32'(busy), 0);
      end
    end
    ack_prev <= ack;
  end

  // done_at = 0 means core_done is never raised; hold > 0 keeps req high that many cycles.
  task automatic run_prog(input int done_at, input bit extra_req, input int hold,
                          input bit done_in_launch);
    res_t r;
    int   k;
    bit   got;
    int   c;
    exp_pc_q.push_back(pc_of(m_id));
    exp_starts++;
    m_id = (m_id + 1) % 3;
    if (done_at == 0 || done_at > int'(TmoTb)) begin
      r.cycles = TmoTb;
      r.tmo    = 1'b1;
    end else begin
      r.cycles = done_at;
      r.tmo    = 1'b0;
    end
    r.id = m_id;
    exp_res_q.push_back(r);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = (hold > 1);
    if (done_in_launch) core_done = 1'b1;
    k = 0;
    got = 1'b0;
    c = 0;
    while ((!got || c + 2 < hold) && c < int'(TmoTb) + 20) begin
      @(posedge clk); #1;
      core_done = 1'b0;
      req = (c + 3 < hold);
      if (!got) begin
        if (ack) begin
          got = 1'b1;
        end else begin
          k++;
          if (k == done_at) core_done = 1'b1;
          if (extra_req && k == 2) req = 1'b1;
        end
      end
      c++;
    end
    req = 1'b0;
    core_done = 1'b0;
    if (!got) check_eq("ack_wait_expired", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 0);
    check_eq({tag, "_start"}, 32'(core_start), 0);
    check_eq({tag, "_pc"}, 32'(core_pc), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
    check_eq({tag, "_prog_id"}, 32'(prog_id), 0);
    check_eq({tag, "_last"}, 32'(last_cycles), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("rst");

    run_prog(5, 1'b0, 0, 1'b0);   // program 0, done on 5th RUN cycle
    run_prog(3, 1'b0, 0, 1'b1);   // core_done during LAUNCH must be ignored
    run_prog(7, 1'b0, 0, 1'b0);   // program 2, id wraps to 0
    run_prog(0, 1'b0, 0, 1'b0);   // timeout
    run_prog(20, 1'b0, 0, 1'b0);  // done coincides with counter == TMO
    run_prog(6, 1'b1, 0, 1'b0);   // extra req edge during RUN
    run_prog(3, 1'b0, 10, 1'b0);  // req held high for 10 cycles

    // Reset on the 3rd RUN cycle of the program at index 1.
    exp_pc_q.push_back(pc_of(m_id));
    exp_starts++;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("mid_run_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_all_zero("mid_rst");
    m_id = 0;

    // req edge coincident with reset is discarded.
    @(posedge clk); #1 reset = 1'b1; req = 1'b1;
    @(posedge clk); #1 reset = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("discard_busy", 32'(busy), 0);

    run_prog(1, 1'b0, 0, 1'b0);   // relaunches core_pc=0, single RUN cycle
    run_prog(2, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("start_count", 32'(n_starts), 32'(exp_starts));
    check_eq("pc_queue_empty", 32'(exp_pc_q.size()), 0);
    check_eq("res_queue_empty", 32'(exp_res_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
- REQ-001: Parameter PW, default 10, SHALL set the program-counter width.
- REQ-002: Parameter PC0, default 0, SHALL set the start address of program 1.
- REQ-003: Parameter PC1, default 128, SHALL set the start address of program 2.
- REQ-004: Parameter PC2, default 256, SHALL set the start address of program 3.
- REQ-005: Parameter TMO, default 16'd60000, SHALL set the run timeout in cycles; legal range is 2..65535.
- REQ-006: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
- REQ-007: Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
- REQ-008: Port req, input, 1 bit, SHALL be the host start request; a rising edge launches the next program.
- REQ-009: Port ack, output, 1 bit, SHALL signal that the current program is complete or aborted.
- REQ-010: Port core_start, output, 1 bit, SHALL be a one-cycle init pulse to the core.
- REQ-011: Port core_pc, output, PW bits, SHALL carry the start address and be valid while core_start=1.
- REQ-012: Port core_done, input, 1 bit, SHALL be the core's completion flag.
- REQ-013: Port prog_id, output, 2 bits, SHALL give the index (0..2) of the next or current program.
- REQ-014: Port busy, output, 1 bit, SHALL be high in LAUNCH and RUN.
- REQ-015: Port timeout, output, 1 bit, SHALL flag that the last program was aborted by timeout.
- REQ-016: Port last_cycles, output, 16 bits, SHALL report the number of RUN cycles of the last program.

Function
- REQ-017: States SHALL be IDLE, LAUNCH and RUN, held in a registered state machine.
- REQ-018: req SHALL be registered into req_q each cycle, and launch SHALL be req & ~req_q sampled in IDLE.
- REQ-019: On launch in cycle n, cycle n+1 SHALL be LAUNCH with core_start=1, core_pc=PC[prog_id], busy=1, ack=0, timeout=0, and the cycle counter cleared.
- REQ-020: LAUNCH SHALL last exactly one cycle and then go to RUN unconditionally; core_done is ignored in LAUNCH.
- REQ-021: In RUN the 16-bit cycle counter SHALL increment by 1 each cycle, starting at 1 in the first RUN cycle.
- REQ-022: core_done=1 sampled in RUN SHALL, on the next cycle, set state=IDLE, ack=1, busy=0, last_cycles=counter value, and advance prog_id.
- REQ-023: prog_id SHALL advance 0->1->2->0 (wrap after 2); value 3 is never produced.
- REQ-024: If the counter equals TMO in RUN and core_done=0, the next cycle SHALL set state=IDLE, ack=1, timeout=1, last_cycles=TMO, and advance prog_id.
- REQ-025: If core_done=1 and counter==TMO in the same cycle, completion SHALL win and timeout SHALL stay 0.
- REQ-026: ack and timeout SHALL hold their values in IDLE until the next launch clears them.
- REQ-027: Rising edges of req in LAUNCH or RUN SHALL be ignored, not queued.
- REQ-028: req held high continuously SHALL produce only one launch; a new launch needs req low for at least one cycle.
- REQ-029: core_pc SHALL be 0 whenever core_start=0.

Reset
- REQ-030: reset=1 at a rising edge SHALL force state=IDLE, ack=0, core_start=0, core_pc=0, busy=0, timeout=0, prog_id=0, last_cycles=0, counter=0 and req_q=0, from any state including mid-RUN.
- REQ-031: A req rising edge coincident with reset SHALL be discarded.

Verification
- REQ-032: Reset; pulse req 1 cycle; core_done=1 on the 5th RUN cycle -> core_start pulse with core_pc=0, then ack=1, last_cycles=5, prog_id=1.
- REQ-033: Three consecutive req/done rounds -> core_pc sequence 0, 128, 256, with prog_id returning to 0 after the third ack.
- REQ-034: TMO=20, core_done never asserted -> ack=1 and timeout=1 in the cycle after counter reaches 20, last_cycles=20; the next launch clears timeout.
- REQ-035: TMO=20, core_done=1 in the cycle counter=20 -> ack=1, timeout=0, last_cycles=20.
- REQ-036: Extra req pulse during RUN, plus req held high for 10 cycles from IDLE -> exactly one core_start per qualifying edge.
- REQ-037: reset asserted on the 3rd RUN cycle of program 2 -> all outputs 0 next cycle, and the next req launches core_pc=0.
